// File: rtl/spi_dispatch_pkg.sv
// rtl/spi_dispatch_pkg.sv - shared opcodes, status codes, field positions and FSM states
package spi_dispatch_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_READ  = 4'h2;
  localparam logic [3:0] OP_BCAST = 4'h3;

  localparam logic [3:0] STATUS_OK      = 4'h0;
  localparam logic [3:0] STATUS_TIMEOUT = 4'hD;
  localparam logic [3:0] STATUS_ILLEGAL = 4'hE;

  localparam int INSTR_OPC_LSB  = 28;
  localparam int INSTR_TGT_LSB  = 24;
  localparam int INSTR_ADDR_LSB = 16;
  localparam int INSTR_DATA_LSB = 0;

  localparam int RB_STATUS_LSB = 28;
  localparam int RB_TGT_LSB    = 24;
  localparam int RB_ADDR_LSB   = 16;
  localparam int RB_DATA_LSB   = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_ISSUE,
    ST_WAIT_ACCEPT,
    ST_WAIT_DONE,
    ST_REPORT
  } state_e;

  function automatic logic [31:0] pack_readback(input logic [3:0] status,
                                                input logic [3:0] tgt,
                                                input logic [7:0] addr,
                                                input logic [15:0] data);
    logic [31:0] w;
    w = '0;
    w[RB_STATUS_LSB +: 4] = status;
    w[RB_TGT_LSB +: 4]    = tgt;
    w[RB_ADDR_LSB +: 8]   = addr;
    w[RB_DATA_LSB +: 16]  = data;
    return w;
  endfunction

endpackage

// File: rtl/phase_timeout.sv
// rtl/phase_timeout.sv - per-phase cycle counter; expired on the TIMEOUT_CYCLES-th cycle of a phase
module phase_timeout #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  assign expired = (count_q >= LIMIT);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/spi_command_dispatcher.sv
// rtl/spi_command_dispatcher.sv - pops instructions, drives per-target SPI requests, reports reads and errors
module spi_command_dispatcher
  import spi_dispatch_pkg::*;
#(
  parameter int NUM_TARGETS    = 4,
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              instr_ready,
  output logic                              instr_ack,
  input  logic [31:0]                       instr_in,
  input  logic                              readback_ready,
  output logic                              readback_write,
  output logic [31:0]                       readback_data,
  output logic [NUM_TARGETS-1:0]            spi_request_write,
  output logic [NUM_TARGETS-1:0]            spi_request_read,
  output logic [ADDR_WIDTH-1:0]             spi_address,
  output logic [DATA_WIDTH-1:0]             spi_data,
  input  logic [NUM_TARGETS*DATA_WIDTH-1:0] spi_data_readback,
  input  logic [NUM_TARGETS-1:0]            spi_busy,
  output logic [15:0]                       error_count,
  output logic                              idle
);

  state_e        state_q, state_d;
  logic [31:0]   instr_q, instr_d;
  logic [3:0]    tgt_q, tgt_d;
  logic [3:0]    status_q, status_d;
  logic [15:0]   data_q, data_d;
  logic [15:0]   err_q, err_d;
  logic          req_fire;
  logic          expired;
  logic          timer_clear;
  logic          timer_enable;
  logic [3:0]    opcode;
  logic [3:0]    instr_tgt;
  logic          tgt_legal;
  logic [15:0]   busy_ext;
  logic          busy_sel;
  logic [DATA_WIDTH-1:0] rd_sel;

  assign opcode    = instr_q[INSTR_OPC_LSB +: 4];
  assign instr_tgt = instr_q[INSTR_TGT_LSB +: 4];
  assign tgt_legal = ({1'b0, instr_tgt} < 5'(NUM_TARGETS));
  assign busy_ext  = 16'(spi_busy);
  assign busy_sel  = busy_ext[tgt_q];

  assign spi_address   = instr_q[INSTR_ADDR_LSB +: ADDR_WIDTH];
  assign spi_data      = instr_q[INSTR_DATA_LSB +: DATA_WIDTH];
  assign error_count   = err_q;
  assign idle          = (state_q == ST_IDLE);
  assign readback_data = (state_q == ST_REPORT)
                         ? pack_readback(status_q, tgt_q, 8'(spi_address), data_q)
                         : '0;

  // Timer restarts on every state entry, including broadcast re-entry into ISSUE.
  assign timer_clear  = (state_d != state_q);
  assign timer_enable = (state_q == ST_ISSUE) || (state_q == ST_WAIT_ACCEPT) ||
                        (state_q == ST_WAIT_DONE);

  phase_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_phase_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expired(expired)
  );

  always_comb begin
    spi_request_write = '0;
    spi_request_read  = '0;
    rd_sel            = '0;
    for (int t = 0; t < NUM_TARGETS; t++) begin
      if (tgt_q == 4'(t)) begin
        spi_request_write[t] = req_fire && ((opcode == OP_WRITE) || (opcode == OP_BCAST));
        spi_request_read[t]  = req_fire && (opcode == OP_READ);
        rd_sel               = spi_data_readback[t*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    instr_d        = instr_q;
    tgt_d          = tgt_q;
    status_d       = status_q;
    data_d         = data_q;
    err_d          = err_q;
    instr_ack      = 1'b0;
    readback_write = 1'b0;
    req_fire       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (instr_ready) begin
          instr_ack = 1'b1;
          instr_d   = instr_in;
          state_d   = ST_DECODE;
        end
      end

      ST_DECODE: begin
        data_d = '0;
        tgt_d  = (opcode == OP_BCAST) ? 4'd0 : instr_tgt;
        if (opcode == OP_NOP) begin
          state_d = ST_IDLE;
        end else if ((opcode == OP_BCAST) ||
                     (((opcode == OP_WRITE) || (opcode == OP_READ)) && tgt_legal)) begin
          state_d = ST_ISSUE;
        end else begin
          status_d = STATUS_ILLEGAL;
          state_d  = ST_REPORT;
        end
      end

      ST_ISSUE: begin
        if (!busy_sel) begin
          req_fire = 1'b1;
          state_d  = ST_WAIT_ACCEPT;
        end else if (expired) begin
          status_d = STATUS_TIMEOUT;
          state_d  = ST_REPORT;
        end
      end

      ST_WAIT_ACCEPT: begin
        if (busy_sel) begin
          state_d = ST_WAIT_DONE;
        end else if (expired) begin
          status_d = STATUS_TIMEOUT;
          state_d  = ST_REPORT;
        end
      end

      ST_WAIT_DONE: begin
        if (!busy_sel) begin
          if (opcode == OP_READ) begin
            data_d   = 16'(rd_sel);
            status_d = STATUS_OK;
            state_d  = ST_REPORT;
          end else if ((opcode == OP_BCAST) && (tgt_q != 4'(NUM_TARGETS - 1))) begin
            tgt_d   = tgt_q + 4'd1;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (expired) begin
          status_d = STATUS_TIMEOUT;
          state_d  = ST_REPORT;
        end
      end

      ST_REPORT: begin
        if (readback_ready) begin
          readback_write = 1'b1;
          state_d        = ST_IDLE;
          if ((status_q != STATUS_OK) && (err_q != 16'hFFFF)) begin
            err_d = err_q + 16'd1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      instr_q  <= '0;
      tgt_q    <= '0;
      status_q <= '0;
      data_q   <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      tgt_q    <= tgt_d;
      status_q <= status_d;
      data_q   <= data_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_spi_command_dispatcher.sv
// tb/tb_spi_command_dispatcher.sv - scoreboard bench with endpoint models and a transaction-level reference
module tb_spi_command_dispatcher;

  localparam int NT = 4;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int TO = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             instr_ready = 1'b0;
  logic             instr_ack;
  logic [31:0]      instr_in = '0;
  logic             readback_ready = 1'b1;
  logic             readback_write;
  logic [31:0]      readback_data;
  logic [NT-1:0]    spi_request_write;
  logic [NT-1:0]    spi_request_read;
  logic [AW-1:0]    spi_address;
  logic [DW-1:0]    spi_data;
  logic [NT*DW-1:0] spi_data_readback = '0;
  logic [NT-1:0]    spi_busy = '0;
  logic [15:0]      error_count;
  logic             idle;

  always #5 clk = ~clk;

  spi_command_dispatcher #(
    .NUM_TARGETS(NT), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .instr_ready(instr_ready), .instr_ack(instr_ack), .instr_in(instr_in),
    .readback_ready(readback_ready), .readback_write(readback_write), .readback_data(readback_data),
    .spi_request_write(spi_request_write), .spi_request_read(spi_request_read),
    .spi_address(spi_address), .spi_data(spi_data),
    .spi_data_readback(spi_data_readback), .spi_busy(spi_busy),
    .error_count(error_count), .idle(idle)
  );

  typedef struct {
    logic        rd;
    int          tgt;
    logic [7:0]  addr;
    logic [15:0] data;
  } req_t;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  req_t        exp_req[$];
  logic [31:0] exp_rb[$];
  logic [31:0] fifo[$];
  logic [15:0] ref_mem[NT][256];
  logic [15:0] ep_mem[NT][256];
  logic [15:0] rb_drv[NT];
  logic [NT-1:0] dead = '0;
  int          ref_err = 0;
  bit          ack_seen = 0;
  bit          req_seen[NT];
  logic        req_rd[NT];
  logic [7:0]  req_addr[NT];
  logic [15:0] req_data[NT];
  int          ep_state[NT];
  int          ep_cnt[NT];
  bit          bp_hold = 0;
  bit          long_busy = 0;
  int          push_cnt = 0;
  int          req_cnt = 0;
  int          last_ack_cyc = 0;
  int          last_req_cyc = 0;
  logic [31:0] last_rb = '0;
  logic [NT-1:0] mon_req;
  req_t        mon_e;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void err_word(input logic [3:0] st, input logic [3:0] tg, input logic [7:0] a);
    exp_rb.push_back({st, tg, a, 16'h0000});
    if (ref_err < 65535) ref_err++;
  endfunction

  // Transaction-level reference: what each instruction must produce, given the dead-endpoint mask.
  function automatic void model(input logic [31:0] w);
    logic [3:0]  op;
    logic [3:0]  tg;
    logic [7:0]  a;
    logic [15:0] d;
    op = w[31:28];
    tg = w[27:24];
    a  = w[23:16];
    d  = w[15:0];
    if (op == 4'h0) begin
    end else if (op == 4'h1 || op == 4'h2) begin
      if (int'(tg) >= NT) begin
        err_word(4'hE, tg, a);
      end else begin
        exp_req.push_back('{rd: (op == 4'h2), tgt: int'(tg), addr: a, data: d});
        if (dead[tg]) err_word(4'hD, tg, a);
        else if (op == 4'h1) ref_mem[tg][a] = d;
        else exp_rb.push_back({4'h0, tg, a, ref_mem[tg][a]});
      end
    end else if (op == 4'h3) begin
      for (int t = 0; t < NT; t++) begin
        exp_req.push_back('{rd: 1'b0, tgt: t, addr: a, data: d});
        if (dead[t]) begin
          err_word(4'hD, 4'(t), a);
          break;
        end
        ref_mem[t][a] = d;
      end
    end else begin
      err_word(4'hE, tg, a);
    end
  endfunction

  task automatic issue(input logic [31:0] w);
    model(w);
    fifo.push_back(w);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic bit eps_idle();
    for (int t = 0; t < NT; t++) if (ep_state[t] != 0) return 0;
    return 1;
  endfunction

  task automatic wait_quiet(input string name);
    int n;
    n = 0;
    while (!(fifo.size() == 0 && exp_rb.size() == 0 && exp_req.size() == 0 && idle &&
             spi_busy == '0 && !ack_seen && eps_idle()) && n < 3000) begin
      step();
      n++;
    end
    if (n >= 3000) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: not quiescent after %0d cycles (pending words %0d, requests %0d)",
               name, n, exp_rb.size(), exp_req.size());
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (instr_ack) begin
        ack_seen     = 1;
        last_ack_cyc = cyc;
      end
      if (readback_write) begin
        push_cnt++;
        if (exp_rb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_readback: got %h expected no push", readback_data);
        end else begin
          check("readback_word", readback_data, exp_rb.pop_front());
        end
        last_rb = readback_data;
      end
      mon_req = spi_request_write | spi_request_read;
      if (mon_req != '0) begin
        check("request_onehot", 32'($onehot(mon_req) && ((spi_request_write & spi_request_read) == '0)), 32'd1);
        for (int t = 0; t < NT; t++) begin
          if (mon_req[t]) begin
            req_cnt++;
            last_req_cyc = cyc;
            check("request_while_busy", 32'(spi_busy[t]), 32'd0);
            req_seen[t] = 1;
            req_rd[t]   = spi_request_read[t];
            req_addr[t] = spi_address;
            req_data[t] = spi_data;
            if (exp_req.size() == 0) begin
              n_cmp++;
              n_fail++;
              $display("FAIL unexpected_request: got target %0d expected none", t);
            end else begin
              mon_e = exp_req.pop_front();
              check("request_target", t, mon_e.tgt);
              check("request_kind", 32'(spi_request_read[t]), 32'(mon_e.rd));
              check("request_addr", 32'(spi_address), 32'(mon_e.addr));
              check("request_data", 32'(spi_data), 32'(mon_e.data));
            end
          end
        end
      end
    end
  end

  // Instruction FIFO front end, readback FIFO space and SPI endpoint behaviour.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ack_seen) begin
        ack_seen = 0;
        if (fifo.size() > 0) void'(fifo.pop_front());
      end
      instr_ready    = (fifo.size() > 0);
      instr_in       = (fifo.size() > 0) ? fifo[0] : 32'h0;
      readback_ready = bp_hold ? 1'b0 : ($urandom_range(3) != 0);
      for (int t = 0; t < NT; t++) begin
        if (req_seen[t]) begin
          req_seen[t] = 0;
          if (!dead[t]) begin
            if (req_rd[t]) rb_drv[t] = ep_mem[t][req_addr[t]];
            else ep_mem[t][req_addr[t]] = req_data[t];
            ep_state[t] = 1;
            ep_cnt[t]   = $urandom_range(3);
          end
        end
        if (ep_state[t] == 1) begin
          if (ep_cnt[t] == 0) begin
            spi_busy[t] = 1'b1;
            ep_state[t] = 2;
            ep_cnt[t]   = long_busy ? 12 : $urandom_range(1, 5);
          end else begin
            ep_cnt[t]--;
          end
        end else if (ep_state[t] == 2) begin
          ep_cnt[t]--;
          if (ep_cnt[t] == 0) begin
            spi_busy[t] = 1'b0;
            ep_state[t] = 0;
          end
        end
        spi_data_readback[t*DW +: DW] = rb_drv[t];
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int r0;
    int n;
    for (int t = 0; t < NT; t++) begin
      rb_drv[t]   = '0;
      req_seen[t] = 0;
      ep_state[t] = 0;
      ep_cnt[t]   = 0;
      for (int a = 0; a < 256; a++) begin
        ref_mem[t][a] = '0;
        ep_mem[t][a]  = '0;
      end
    end

    reset = 1'b1;
    repeat (3) step();
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_ack", 32'(instr_ack), 32'd0);
    check("rst_rbwrite", 32'(readback_write), 32'd0);
    check("rst_rbdata", readback_data, 32'h0);
    check("rst_requests", 32'({spi_request_write, spi_request_read}), 32'h0);
    check("rst_addr_data", 32'({spi_address, spi_data}), 32'h0);
    check("rst_errcnt", 32'(error_count), 32'h0);
    reset = 1'b0;
    step();

    p0 = push_cnt;
    issue(32'h1205ABCD);
    wait_quiet("write");
    check("write_latency", last_req_cyc - last_ack_cyc, 2);
    check("write_no_readback", push_cnt, p0);

    ep_mem[1][8'h10]  = 16'h1234;
    ref_mem[1][8'h10] = 16'h1234;
    issue(32'h21100000);
    wait_quiet("read");
    check("read_word", last_rb, 32'h01101234);

    r0 = req_cnt;
    issue(32'h300700FF);
    wait_quiet("bcast");
    check("bcast_requests", req_cnt - r0, 4);

    issue(32'h19050000);
    issue(32'h70000000);
    wait_quiet("illegal");
    check("illegal_last_word", last_rb, 32'hE0000000);
    check("illegal_errcnt", 32'(error_count), 32'd2);

    dead[3] = 1'b1;
    issue(32'h13220055);
    wait_quiet("timeout");
    dead = '0;
    check("timeout_word", last_rb, 32'hD3220000);
    check("timeout_errcnt", 32'(error_count), 32'd3);
    check("timeout_idle", 32'(idle), 32'd1);

    bp_hold = 1;
    ep_mem[2][8'h03]  = 16'hBEEF;
    ref_mem[2][8'h03] = 16'hBEEF;
    p0 = push_cnt;
    issue(32'h22030000);
    repeat (50) step();
    check("bp_held_word", readback_data, 32'h0203BEEF);
    check("bp_no_push", push_cnt, p0);
    check("bp_not_idle", 32'(idle), 32'd0);
    bp_hold = 0;
    wait_quiet("backpressure");
    check("bp_single_push", push_cnt, p0 + 1);

    long_busy = 1;
    issue(32'h21100000);
    n = 0;
    while (!spi_busy[1] && n < 100) begin
      step();
      n++;
    end
    check("reset_busy_seen", 32'(spi_busy[1]), 32'd1);
    step();
    reset = 1'b1;
    step();
    check("midrst_idle", 32'(idle), 32'd1);
    check("midrst_requests", 32'({spi_request_write, spi_request_read}), 32'h0);
    check("midrst_addr_data", 32'({spi_address, spi_data}), 32'h0);
    check("midrst_rbdata", readback_data, 32'h0);
    check("midrst_errcnt", 32'(error_count), 32'h0);
    exp_rb.delete();
    ref_err = 0;
    reset   = 1'b0;
    long_busy = 0;
    wait_quiet("reset_recover");

    for (int b = 0; b < 20; b++) begin
      dead = '0;
      if ($urandom_range(3) == 0) dead[$urandom_range(NT - 1)] = 1'b1;
      for (int i = 0; i < 6; i++) begin
        int          k;
        logic [3:0]  op;
        logic [3:0]  tg;
        logic [7:0]  a;
        logic [15:0] d;
        k  = $urandom_range(9);
        op = (k < 3) ? 4'h1 : (k < 6) ? 4'h2 : (k < 8) ? 4'h3 : (k == 8) ? 4'h0 : 4'($urandom_range(4, 15));
        tg = 4'($urandom_range(5));
        a  = 8'($urandom_range(7));
        d  = 16'($urandom);
        issue({op, tg, a, d});
      end
      wait_quiet("random_batch");
      check("random_errcnt", 32'(error_count), 32'(ref_err));
    end
    dead = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
